down_counter_sched: RTL and testbench

Round-robin scheduler that shares one W-bit down counter among NREQ requesters. Each requester asks for a countdown and supplies its own load value. The scheduler grants one requester at a time, loads its value into the shared counter, runs it down to zero and returns a one-cycle completion pulse to that requester. It sits between the timing clients and the shared countdown datapath, and owns all sequencing of that counter.

---
 rtl/down_counter_sched.sv | 105 ++++++++++
 tb/tb_down_counter_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// down_counter_sched : round-robin sharing of one W-bit down counter among
//                      NREQ requesters, with a one-cycle done pulse per run.
// Revision 1.0
// ---------------------------------------------------------------------------
module down_counter_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] load_val,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      count,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] gidx_next;
  logic [PW-1:0] win;
  logic          win_valid;
  logic [W-1:0]  win_load;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    win       = ptr;
    win_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win       = PW'(idx);
        win_valid = 1'b1;
      end
    end
  end

  assign win_load  = load_val[int'(win)*W +: W];
  assign gidx_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      done  <= '0;
      count <= '1;
      ptr   <= '0;
      gidx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (win_valid) begin
            grant <= ONE_HOT0 << win;
            gidx  <= win;
            count <= win_load;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort takes priority over completion; count is left frozen.
          if (!req[gidx]) begin
            grant <= '0;
            ptr   <= gidx_next;
            state <= ST_IDLE;
          end else if (count == '0) begin
            done  <= grant;
            grant <= '0;
            ptr   <= gidx_next;
            state <= ST_DONE;
          end else begin
            count <= count - W'(1);
          end
        end
        ST_DONE: begin
          done  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          grant <= '0;
          done  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_down_counter_sched.sv
`default_nettype none
// Scoreboard bench for down_counter_sched: directed scenarios queue expected
// grant/done events; a negedge monitor pops and compares them.
module tb_down_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] load_val = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      count;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int e        = 0;

  typedef struct {
    bit is_done;
    int idx;
    int cnt;
    int cyc;
  } ev_t;

  ev_t             q[$];
  logic [NREQ-1:0] prev_grant = '0;

  down_counter_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .grant    (grant),
    .done     (done),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(bit is_done, int idx, int cnt, int c);
    ev_t ev;
    ev.is_done = is_done;
    ev.idx     = idx;
    ev.cnt     = cnt;
    ev.cyc     = c;
    q.push_back(ev);
  endfunction

  task automatic take_event(bit is_done);
    ev_t             ev;
    logic [NREQ-1:0] act;
    act = is_done ? done : grant;
    if (q.size() == 0) begin
      check(is_done ? "unexpected_done" : "unexpected_grant", 32'(act), 0);
      return;
    end
    ev = q.pop_front();
    check(is_done ? "done_kind" : "grant_kind", 32'(is_done), 32'(ev.is_done));
    check(is_done ? "done_bits" : "grant_bits", 32'(act), 32'(1) << ev.idx);
    check(is_done ? "done_cycle" : "grant_cycle", cyc, ev.cyc);
    if (!is_done) check("grant_count", 32'(count), ev.cnt);
  endtask

  // Monitor: a grant event is a rising grant vector, a done event any done bit.
  always @(negedge clk) begin
    if (grant != '0 && prev_grant == '0) take_event(1'b0);
    if (done != '0) take_event(1'b1);
    prev_grant = grant;
  end

  task automatic neg(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_load(int idx, int v);
    load_val[idx*W +: W] = v[W-1:0];
  endtask

  task automatic chk_reset(string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_count"}, 32'(count), 15);
    check({tag, "_busy"},  32'(busy), 0);
  endtask

  task automatic run_one(int idx, int l);
    int e0;
    req      = '0;
    req[idx] = 1'b1;
    set_load(idx, l);
    e0 = cyc + 1;
    push(1'b0, idx, l, e0);
    push(1'b1, idx, 0, e0 + l + 1);
    for (int k = 1; k <= l + 2; k++) begin
      neg(1);
      if (k <= l + 1) check("run_count", 32'(count), l - k + 1);
      check("run_busy", 32'(busy), 1);
    end
    req[idx] = 1'b0;
    neg(1);
    check("idle_busy", 32'(busy), 0);
    check("idle_grant", 32'(grant), 0);
    neg(1);
  endtask

  initial begin
    // Reset, then asynchronous reset in the middle of a countdown.
    neg(1);
    chk_reset("por");
    rst = 1'b0;
    neg(1);
    req = 4'b0001;
    set_load(0, 9);
    e = cyc + 1;
    push(1'b0, 0, 9, e);
    neg(5);
    check("pre_reset_count", 32'(count), 5);
    #2 rst = 1'b1;
    #1 chk_reset("async");
    neg(1);
    rst = 1'b0;
    req = 4'b0010;
    set_load(1, 2);
    e = cyc + 1;
    push(1'b0, 1, 2, e);
    push(1'b1, 1, 0, e + 3);
    neg(4);
    req = '0;
    neg(2);

    // Zero load on requester 2.
    run_one(2, 0);

    // Abort requester 2 at count 5; requester 3 then wins over 0.
    req = 4'b0100;
    set_load(2, 8);
    e = cyc + 1;
    push(1'b0, 2, 8, e);
    neg(4);
    check("abort_pre_count", 32'(count), 5);
    req = 4'b1001;
    set_load(3, 1);
    set_load(0, 1);
    push(1'b0, 3, 1, e + 5);
    push(1'b1, 3, 0, e + 7);
    neg(1);
    check("abort_grant", 32'(grant), 0);
    check("abort_count", 32'(count), 5);
    check("abort_busy", 32'(busy), 0);
    neg(3);
    req = '0;
    neg(2);

    // Fairness: all requesters held, load 1, grants every 4 cycles.
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) set_load(k, 1);
    e = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      push(1'b0, k % 4, 1, e + 4*k);
      push(1'b1, k % 4, 0, e + 4*k + 2);
    end
    neg(17);
    req = 4'b0001;
    neg(2);
    req = '0;
    neg(2);

    // Single request, load 3.
    run_one(0, 3);

    // Round-robin skip: 2 -> 3 -> 1, late req0 waits until after 1.
    req = 4'b0100;
    set_load(2, 2);
    e = cyc + 1;
    push(1'b0, 2, 2, e);
    push(1'b1, 2, 0, e + 3);
    push(1'b0, 3, 1, e + 5);
    push(1'b1, 3, 0, e + 7);
    push(1'b0, 1, 1, e + 9);
    push(1'b1, 1, 0, e + 11);
    push(1'b0, 0, 0, e + 13);
    push(1'b1, 0, 0, e + 14);
    neg(1);
    set_load(1, 1);
    set_load(3, 1);
    set_load(0, 0);
    req = 4'b1111;
    neg(1);
    req[0] = 1'b0;
    neg(2);
    req[2] = 1'b0;
    neg(4);
    req[3] = 1'b0;
    neg(2);
    req[0] = 1'b1;
    neg(2);
    req[1] = 1'b0;
    neg(3);
    req[0] = 1'b0;
    neg(3);

    check("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
